// File: rtl/k_means_pkg.sv
// Shared k-means definitions: APB master state encoding and the register-file
// index map used by both the APB host and the register file.
package k_means_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_master_st_t;

  localparam int unsigned RegStatus       = 0;
  localparam int unsigned RegGo           = 1;
  localparam int unsigned RegCentroidBase = 2;
  localparam int unsigned RegCentroidLast = 9;
  localparam int unsigned RegRamAddr      = 10;
  localparam int unsigned RegRamData      = 11;
  localparam int unsigned RegFirstRamAddr = 12;
  localparam int unsigned RegLastRamAddr  = 13;
  localparam int unsigned RegThreshold    = 14;

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts stalled ACCESS cycles; terminal is raised on the last allowed cycle
// so the master can abort on that same clock edge.
module apb_timeout_counter #(
  parameter int unsigned MaxCount = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int unsigned CntW = $clog2(MaxCount + 1);

  logic [CntW-1:0] cnt_q;

  assign terminal = enable && (cnt_q == CntW'(MaxCount - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !terminal) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/apb_host_master.sv
// APB initiator: one register command at a time, SETUP->ACCESS, one-cycle
// response. Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES.
module apb_host_master
  import k_means_pkg::*;
#(
  parameter int unsigned addrWidth      = 9,
  parameter int unsigned dataWidth      = 91,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [addrWidth-1:0] cmd_addr,
  input  logic [dataWidth-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [dataWidth-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic [addrWidth-1:0] paddr,
  output logic                 pwrite,
  output logic                 psel,
  output logic                 penable,
  output logic [dataWidth-1:0] pwdata,
  input  logic [dataWidth-1:0] prdata,
  input  logic                 pready
);

  apb_master_st_t state_q, state_d;

  logic                 accept;
  logic                 timeout;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [dataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [addrWidth-1:0] paddr_q;
  logic                 pwrite_q;
  logic [dataWidth-1:0] pwdata_q;

  // Bus control comes straight from the state register so an async reset
  // drops psel/penable in the same cycle.
  assign cmd_ready = (state_q == IDLE);
  assign psel      = (state_q != IDLE);
  assign penable   = (state_q == ACCESS);
  assign accept    = cmd_valid && cmd_ready;

  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

`ifdef APB_TIMEOUT_EN
  apb_timeout_counter #(
    .MaxCount (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept),
    .enable   ((state_q == ACCESS) && !pready),
    .terminal (timeout)
  );
  assign rsp_err = rsp_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES ^ rsp_err_q;
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) state_d = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
        end else if (timeout) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Command fields stay on the bus until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
    end else if (accept) begin
      paddr_q  <= cmd_addr;
      pwrite_q <= cmd_write;
      pwdata_q <= cmd_wdata;
    end
  end

endmodule

// File: tb/tb_apb_host_master.sv
// Bench for apb_host_master: register-file slave model, response scoreboard
// and directed command sequences.
module tb_apb_host_master;
  import k_means_pkg::*;

  localparam int AW = 9;
  localparam int DW = 91;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          slv_rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic          psel;
  logic          penable;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;

  logic          force_rdy = 1'b0;
  logic          stall_en = 1'b0;
  logic [DW-1:0] mem [16];
  logic          prev_psel = 1'b0;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  apb_host_master #(
    .addrWidth      (AW),
    .dataWidth      (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .psel      (psel),
    .penable   (penable),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready)
  );

  // Slave: registered pready one cycle into ACCESS; ignores the bus while GO is set.
  assign prdata = mem[paddr[3:0]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pready <= 1'b0;
    else pready <= force_rdy | (psel & penable & ~pready & ~(stall_en & mem[RegGo][0]));
  end

  always @(posedge clk or negedge slv_rst_n) begin
    if (!slv_rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (psel && penable && pready && pwrite) begin
      mem[paddr[3:0]] <= pwdata;
    end
  end

  // Scoreboard monitor and APB ordering check.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected rdata=%0h err=%0b", rsp_rdata, rsp_err);
      end else begin
        mon_e = exp_q.pop_front();
        if (rsp_rdata !== mon_e.rdata || rsp_err !== mon_e.err) begin
          bad++;
          $display("FAIL rsp_data got rdata=%0h err=%0b want rdata=%0h err=%0b",
                   rsp_rdata, rsp_err, mon_e.rdata, mon_e.err);
        end
      end
    end
    if (penable) begin
      total++;
      if (!psel || !prev_psel) begin
        bad++;
        $display("FAIL apb_order penable without prior SETUP psel=%0b prev_psel=%0b",
                 psel, prev_psel);
      end
    end
    prev_psel = psel;
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask

  // Present a command at the current (negedge) time and hold it through the accept edge.
  task automatic start_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW-1:0] er, input logic ee);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", DW'(cmd_ready), DW'(1));
    exp_q.push_back('{rdata: er, err: ee});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 200);
    chk("rsp_arrived", DW'(rsp_valid), DW'(1));
  endtask

  initial begin
    int n;
    int acc;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", DW'(cmd_ready), DW'(1));
    chk("rst_psel", DW'(psel), DW'(0));
    chk("rst_penable", DW'(penable), DW'(0));
    chk("rst_rsp_valid", DW'(rsp_valid), DW'(0));
    chk("rst_rsp_err", DW'(rsp_err), DW'(0));
    chk("rst_rsp_rdata", rsp_rdata, '0);
    chk("rst_paddr", DW'(paddr), DW'(0));
    chk("rst_pwdata", pwdata, '0);
    rst_n = 1'b1;
    slv_rst_n = 1'b1;

    // Write idx 11: check SETUP then ACCESS shape
    @(negedge clk);
    start_cmd(1'b1, AW'(RegRamData), DW'('h5A), '0, 1'b0);
    @(negedge clk);
    chk("t1_setup_psel", DW'(psel), DW'(1));
    chk("t1_setup_penable", DW'(penable), DW'(0));
    chk("t1_paddr", DW'(paddr), DW'(11));
    chk("t1_pwrite", DW'(pwrite), DW'(1));
    chk("t1_pwdata", pwdata, DW'('h5A));
    @(negedge clk);
    chk("t1_access_penable", DW'(penable), DW'(1));
    wait_rsp(n);

    // Write then read centroid 1, with latency counted in cycles after accept
    @(negedge clk);
    start_cmd(1'b1, AW'(RegCentroidBase), DW'('h1234), '0, 1'b0);
    wait_rsp(n);
    @(negedge clk);
    start_cmd(1'b0, AW'(RegCentroidBase), '0, DW'('h1234), 1'b0);
    wait_rsp(n);
    chk("t2_latency", DW'(n), DW'(4));

    // Back-to-back accept in the response cycle
    @(negedge clk);
    start_cmd(1'b1, AW'(RegThreshold), DW'('hABC), '0, 1'b0);
    wait_rsp(n);
    @(negedge clk);
    start_cmd(1'b1, AW'(5), DW'('h77), '0, 1'b0);
    wait_rsp(n);
    chk("t3_ready_in_rsp", DW'(cmd_ready), DW'(1));
    start_cmd(1'b0, AW'(RegThreshold), '0, DW'('hABC), 1'b0);
    @(negedge clk);
    chk("t3_setup_psel", DW'(psel), DW'(1));
    chk("t3_setup_penable", DW'(penable), DW'(0));
    chk("t3_paddr", DW'(paddr), DW'(14));
    chk("t3_pwrite", DW'(pwrite), DW'(0));
    wait_rsp(n);

    // pready held high while idle
    @(negedge clk);
    force_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_idle_ready", DW'(cmd_ready), DW'(1));
      chk("t6_idle_psel", DW'(psel), DW'(0));
      chk("t6_idle_rsp", DW'(rsp_valid), DW'(0));
    end
    force_rdy = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during ACCESS
    start_cmd(1'b0, AW'(RegCentroidBase), '0, DW'('h1234), 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("t5_in_access", DW'(penable), DW'(1));
    rst_n = 1'b0;
    #1;
    chk("t5_rst_psel", DW'(psel), DW'(0));
    chk("t5_rst_penable", DW'(penable), DW'(0));
    chk("t5_rst_rsp", DW'(rsp_valid), DW'(0));
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_rsp", DW'(rsp_valid), DW'(0));
    end
    start_cmd(1'b0, AW'(RegCentroidBase), '0, DW'('h1234), 1'b0);
    wait_rsp(n);

`ifdef APB_TIMEOUT_EN
    // GO set: slave stops answering, so the read times out
    stall_en = 1'b1;
    @(negedge clk);
    start_cmd(1'b1, AW'(RegGo), DW'(1), '0, 1'b0);
    wait_rsp(n);
    @(negedge clk);
    start_cmd(1'b0, AW'(RegCentroidBase + 1), '0, '0, 1'b1);
    acc = 0;
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
      if (penable) acc++;
    end
    chk("t4_rsp_seen", DW'(rsp_valid), DW'(1));
    chk("t4_access_cycles", DW'(acc), DW'(TO));
    chk("t4_psel_dropped", DW'(psel), DW'(0));
    stall_en = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("queue_empty", DW'(exp_q.size()), DW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
